// File: rtl/elevator_lift_if.sv
// Request/status bundle between the button decode, the lift controller and
// the floor display / motor / door actuators.
interface elevator_lift_if;
  logic [2:0] req;
  logic [1:0] current_floor;
  logic       door_open;
  logic       moving;

  modport master (output req, input current_floor, door_open, moving);
  modport slave  (input req, output current_floor, door_open, moving);
endinterface

// File: rtl/elevator_lift.sv
// Three-floor elevator controller: latches floor requests, hops one floor per
// TRAVEL_CYCLES using a keep-direction (SCAN) policy and holds the door open
// for DOOR_CYCLES at each requested floor.
module elevator_lift #(
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic            clk,
  input  logic            reset,
  elevator_lift_if.slave  bus
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES   > 1) ? $clog2(DOOR_CYCLES)   : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR      = 2'd3;

  logic [1:0]    state;
  logic [2:0]    pending;
  logic          dir_up;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dcnt;
  logic [1:0]    floor_q;
  logic          door_q;
  logic          moving_q;

  logic [2:0]    pn;
  logic [1:0]    nf;
  logic [2:0]    cur_m, nf_m;
  logic          cur_hit, any_above, any_below;
  logic          nf_hit, nf_beyond;

  // One-hot mask of a floor.
  function automatic logic [2:0] fmask(input logic [1:0] f);
    case (f)
      2'd0:    fmask = 3'b001;
      2'd1:    fmask = 3'b010;
      2'd2:    fmask = 3'b100;
      default: fmask = 3'b000;
    endcase
  endfunction

  // Floors strictly above f.
  function automatic logic [2:0] above_m(input logic [1:0] f);
    case (f)
      2'd0:    above_m = 3'b110;
      2'd1:    above_m = 3'b100;
      default: above_m = 3'b000;
    endcase
  endfunction

  // Floors strictly below f.
  function automatic logic [2:0] below_m(input logic [1:0] f);
    case (f)
      2'd1:    below_m = 3'b001;
      2'd2:    below_m = 3'b011;
      default: below_m = 3'b000;
    endcase
  endfunction

  // Requests seen this edge plus the floor the current hop lands on.
  always_comb begin
    pn = pending | bus.req;
    nf = floor_q;
    if (state == MOVE_UP && floor_q != 2'd2)
      nf = floor_q + 2'd1;
    else if (state == MOVE_DOWN && floor_q != 2'd0)
      nf = floor_q - 2'd1;
    cur_m     = fmask(floor_q);
    nf_m      = fmask(nf);
    cur_hit   = |(pn & cur_m);
    any_above = |(pn & above_m(floor_q));
    any_below = |(pn & below_m(floor_q));
    nf_hit    = |(pn & nf_m);
    nf_beyond = (state == MOVE_UP) ? |(pn & above_m(nf)) : |(pn & below_m(nf));
  end

  // Controller state, request latch, hop/dwell counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= 3'b000;
      dir_up   <= 1'b1;
      tcnt     <= '0;
      dcnt     <= '0;
      floor_q  <= 2'd0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      pending <= pn;
      case (state)
        IDLE: begin
          if (cur_hit) begin
            state   <= DOOR;
            door_q  <= 1'b1;
            dcnt    <= '0;
            pending <= pn & ~cur_m;
          end else if (any_above && (dir_up || !any_below)) begin
            state    <= MOVE_UP;
            dir_up   <= 1'b1;
            moving_q <= 1'b1;
            tcnt     <= '0;
          end else if (any_below) begin
            state    <= MOVE_DOWN;
            dir_up   <= 1'b0;
            moving_q <= 1'b1;
            tcnt     <= '0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (tcnt == T_LAST) begin
            floor_q <= nf;
            tcnt    <= '0;
            if (nf_hit) begin
              state    <= DOOR;
              moving_q <= 1'b0;
              door_q   <= 1'b1;
              dcnt     <= '0;
              pending  <= pn & ~nf_m;
            end else if (!nf_beyond) begin
              // Nothing further this way: settle and let IDLE pick a direction.
              state    <= IDLE;
              moving_q <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DOOR: begin
          // A press for this floor while open extends the dwell, never re-queues.
          pending <= pn & ~cur_m;
          if (|(bus.req & cur_m)) begin
            dcnt <= '0;
          end else if (dcnt == D_LAST) begin
            state  <= IDLE;
            door_q <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.current_floor = floor_q;
  assign bus.door_open     = door_q;
  assign bus.moving        = moving_q;

endmodule

// File: tb/tb_elevator_lift.sv
// Directed bench for elevator_lift: a table of per-cycle {req, expected
// outputs} records walked from reset, plus hand-written async-reset and
// held-request sequences.
module tb_elevator_lift;

  typedef struct {
    logic [2:0] req;
    logic [1:0] floor;
    logic       door;
    logic       moving;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t vecs[$];

  elevator_lift_if bus ();

  elevator_lift #(.TRAVEL_CYCLES(2), .DOOR_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [2:0] r, input logic [1:0] f, input logic d, input logic m);
    vec_t v;
    v.req = r; v.floor = f; v.door = d; v.moving = m;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] f,
                       input logic d, input logic m);
    n_cmp++;
    if (bus.current_floor !== f || bus.door_open !== d || bus.moving !== m) begin
      n_err++;
      $display("FAIL %s[%0d]: got floor=%0d door=%b moving=%b, required floor=%0d door=%b moving=%b",
               name, idx, bus.current_floor, bus.door_open, bus.moving, f, d, m);
    end
  endtask

  // Drive req on the falling edge, check #1 after the next rising edge.
  task automatic step(input logic [2:0] r);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    bus.req = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    bus.req = 3'b000;

    // single request to floor 1
    add(3'b010,0,0,1); add(3'b000,0,0,1); add(3'b000,1,1,0); add(3'b000,1,1,0);
    add(3'b000,1,1,0); add(3'b000,1,0,0); add(3'b000,1,0,0);
    // request for current floor (1)
    add(3'b010,1,1,0); add(3'b000,1,1,0); add(3'b000,1,1,0); add(3'b000,1,0,0);
    // down to 0 (nothing above, so reverse)
    add(3'b001,1,0,1); add(3'b000,1,0,1); add(3'b000,0,1,0); add(3'b000,0,1,0);
    add(3'b000,0,1,0); add(3'b000,0,0,0);
    // request for current floor 0
    add(3'b001,0,1,0); add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,0,0);
    // multi-stop up: 1 then 2
    add(3'b110,0,0,1); add(3'b000,0,0,1); add(3'b000,1,1,0); add(3'b000,1,1,0);
    add(3'b000,1,1,0); add(3'b000,1,0,0); add(3'b000,1,0,1); add(3'b000,1,0,1);
    add(3'b000,2,1,0); add(3'b000,2,1,0); add(3'b000,2,1,0); add(3'b000,2,0,0);
    // 2 -> 0 passing 1 without stopping
    add(3'b001,2,0,1); add(3'b000,2,0,1); add(3'b000,1,0,1); add(3'b000,1,0,1);
    add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,0,0);
    // up to 2; floor 0 requested while leaving it stays pending
    add(3'b100,0,0,1); add(3'b101,0,0,1); add(3'b000,1,0,1); add(3'b000,1,0,1);
    add(3'b000,2,1,0); add(3'b000,2,1,0); add(3'b000,2,1,0); add(3'b000,2,0,0);
    add(3'b000,2,0,1); add(3'b000,2,0,1); add(3'b000,1,0,1); add(3'b000,1,0,1);
    add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,0,0);
    add(3'b000,0,0,0);
    // at floor 1 with dir=UP, requests both ways: serve 2 first, then 0
    add(3'b010,0,0,1); add(3'b000,0,0,1); add(3'b000,1,1,0); add(3'b101,1,1,0);
    add(3'b000,1,1,0); add(3'b000,1,0,0); add(3'b000,1,0,1); add(3'b000,1,0,1);
    add(3'b000,2,1,0); add(3'b000,2,1,0); add(3'b000,2,1,0); add(3'b000,2,0,0);
    add(3'b000,2,0,1); add(3'b000,2,0,1); add(3'b000,1,0,1); add(3'b000,1,0,1);
    add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,1,0); add(3'b000,0,0,0);

    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].req);
      check("vec", i, vecs[i].floor, vecs[i].door, vecs[i].moving);
    end

    // asynchronous reset in the middle of the second hop toward floor 2
    step(3'b100); check("hop", 0, 2'd0, 1'b0, 1'b1);
    step(3'b000); check("hop", 1, 2'd0, 1'b0, 1'b1);
    step(3'b000); check("hop", 2, 2'd1, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    // pending request for 2 must have been dropped
    for (int i = 0; i < 3; i++) begin
      step(3'b000);
      check("post_reset_idle", i, 2'd0, 1'b0, 1'b0);
    end

    // held request: dwell restarts while req[1] stays high
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(3'b010);
      if (i < 2) check("held", i, 2'd0, 1'b0, 1'b1);
      else       check("held", i, 2'd1, 1'b1, 1'b0);
    end
    step(3'b000); check("held_release", 0, 2'd1, 1'b1, 1'b0);
    step(3'b000); check("held_release", 1, 2'd1, 1'b1, 1'b0);
    step(3'b000); check("held_release", 2, 2'd1, 1'b0, 1'b0);
    step(3'b000); check("held_release", 3, 2'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_lift.md
Name: elevator_lift

Overview:
Three-floor elevator controller FSM (floors 0..2). Latches one-hot floor requests, moves the car one floor per fixed travel interval using a SCAN (keep-direction) policy, and opens the door for a fixed dwell at each requested floor. It is a standalone control block: requests come from button decode logic, and outputs drive the floor display and the motor/door actuators.

Parameters:
TRAVEL_CYCLES, 2, clock cycles per one-floor hop (moving high for exactly this many cycles per hop); legal range ≥1.
DOOR_CYCLES, 3, clock cycles door_open stays high per stop; legal range ≥1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  3  one-hot-or-multi-hot floor requests; bit i = floor i. Sampled every edge, level or pulse.
current_floor  output  2  registered car floor, 0..2; value 3 never produced.
door_open  output  1  registered; high while the door is open at current_floor.
moving  output  1  registered; high while the car is travelling between floors.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, current_floor=0, door_open=0, moving=0, pending=000, dir=UP, counters=0. Takes effect immediately, including mid-hop or mid-dwell. The car restarts logically at floor 0 on release.
- pending[2:0]: every edge, pn = pending | req. Decisions in a cycle use pn. A bit clears when the door opens at that floor.
- door_open and moving are never both 1.
- States:
  - IDLE:
    - If pn[current_floor]: go to DOOR, door_open=1, clear that bit.
    - Else if any pn above current_floor and (dir=UP or nothing pending below): go to MOVE_UP, dir=UP.
    - Else if any pn below: go to MOVE_DOWN, dir=DOWN.
    - Else stay in IDLE.
    - A request is acted on at the same edge it is sampled. There is one cycle from req to moving or door_open.
  - MOVE_UP / MOVE_DOWN: moving=1, hop counter runs. At the edge ending the TRAVEL_CYCLES-th cycle, current_floor is updated by ±1.
    - If pn[new floor]: moving=0, door_open=1, go to DOOR, clear the bit.
    - Else if pn exists beyond the new floor in the same direction: start the next hop with moving held high.
    - Else: moving=0, go to IDLE, which re-evaluates (reversal).
    - New requests never abort a hop in progress.
  - DOOR: door_open=1 for DOOR_CYCLES cycles.
    - A req for current_floor during dwell restarts the dwell count and keeps the bit cleared.
    - At expiry: door_open=0, go to IDLE.
- Boundary rules:
  - Never move up from floor 2 or down from floor 0.
  - Simultaneous requests above and below are resolved by dir.
  - A request for the floor the car is currently leaving (mid-hop) stays pending and is served later.
  - req=000 with nothing pending: idle, all outputs hold.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. current_floor=0, door_open=0, moving=0. Assert reset=0 asynchronously mid-hop: outputs return to 0 before the next clk edge.
- Single request: after reset, req=010 for one edge (then 000). Next cycle moving=1 for 2 cycles. Then current_floor=1, moving=0, door_open=1 for 3 cycles. Then door_open=0, idle at floor 1.
- Held request: req=010 held for 10 cycles, then cleared. The car serves floor 1 once, and the door dwell restarts each cycle req[1] is high. door_open falls 3 cycles after req clears, and the car stays at 1.
- Multi-stop up: at floor 0, req=110 pulse. Car stops at 1 (door 3 cycles), then at 2. Sequence of current_floor is 0,1,2, with two separate door openings.
- Direction preference: car moving 0→1 with dir=UP; during the hop, req=101. Car serves 2 first, then travels down to 0 (passes 1 without stopping).
- Current-floor request: idle at floor 0, req=001. The next cycle door_open=1, moving stays 0, current_floor stays 0.
